// File: rtl/bus_server_responder_if.sv
// Handshake and data bundle between the arbiter/clients, the server responder
// and the downstream sink.
interface bus_server_responder_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        address_to_be_served;
  logic              client_1_rq;
  logic              client_2_rq;
  logic              client_3_rq;
  logic              client_4_rq;
  logic [DATA_W-1:0] client_1_data;
  logic [DATA_W-1:0] client_2_data;
  logic [DATA_W-1:0] client_3_data;
  logic [DATA_W-1:0] client_4_data;
  logic [3:0]        client_rd;
  logic [3:0]        client_done;
  logic              server_ack;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_client;
  logic              out_last;
  logic              busy;

  modport slave (
    input  address_to_be_served,
    input  client_1_rq, client_2_rq, client_3_rq, client_4_rq,
    input  client_1_data, client_2_data, client_3_data, client_4_data,
    input  out_ready,
    output client_rd, client_done, server_ack,
    output out_data, out_valid, out_client, out_last, busy
  );

  modport master (
    output address_to_be_served,
    output client_1_rq, client_2_rq, client_3_rq, client_4_rq,
    output client_1_data, client_2_data, client_3_data, client_4_data,
    output out_ready,
    input  client_rd, client_done, server_ack,
    input  out_data, out_valid, out_client, out_last, busy
  );
endinterface

// File: rtl/bus_server_responder.sv
// Server end of the arbiter handshake: drains up to BURST_LEN words from the
// granted client onto a valid/ready stream, then acknowledges the grant.
module bus_server_responder #(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_server_responder_if.slave bus
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam logic [CW-1:0] BEAT_MAX   = CW'(BURST_LEN);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {SETTLE, CHECK, LOAD, SEND, ACK} state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     settle_cnt;
  logic [CW-1:0]     beat_cnt;
  logic [1:0]        addr_q;
  logic              granted_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [1:0]        out_client_q;
  logic              out_last_q;
  logic [3:0]        rd, done;
  logic              ack;

  logic [3:0]        rq;
  logic [DATA_W-1:0] data [4];
  logic              rq_addr, rq_sel;

  assign rq      = {bus.client_4_rq, bus.client_3_rq, bus.client_2_rq, bus.client_1_rq};
  assign data[0] = bus.client_1_data;
  assign data[1] = bus.client_2_data;
  assign data[2] = bus.client_3_data;
  assign data[3] = bus.client_4_data;
  assign rq_addr = rq[bus.address_to_be_served];
  assign rq_sel  = rq[addr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SETTLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd       = '0;
    done     = '0;
    ack      = 1'b0;
    case (state)
      SETTLE: if (settle_cnt == SETTLE_END) state_nx = CHECK;
      CHECK:  state_nx = rq_addr ? LOAD : ACK;
      LOAD: begin
        if (rq_sel) begin
          rd[addr_q] = 1'b1;
          state_nx   = SEND;
        end else begin
          state_nx   = ACK;
        end
      end
      SEND: begin
        if (out_valid_q && bus.out_ready)
          state_nx = (beat_cnt == BEAT_MAX) ? ACK : LOAD;
      end
      ACK: begin
        ack = 1'b1;
        // Empty grants still release the arbiter but report no finished client.
        if (granted_q) done[addr_q] = 1'b1;
        state_nx = SETTLE;
      end
      default: state_nx = SETTLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt   <= '0;
      beat_cnt     <= '0;
      addr_q       <= '0;
      granted_q    <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_client_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      case (state)
        SETTLE: settle_cnt <= (settle_cnt == SETTLE_END) ? '0 : settle_cnt + 1'b1;
        CHECK: begin
          addr_q    <= bus.address_to_be_served;
          beat_cnt  <= '0;
          granted_q <= rq_addr;
        end
        LOAD: begin
          if (rq_sel) begin
            out_data_q   <= data[addr_q];
            out_valid_q  <= 1'b1;
            out_client_q <= addr_q;
            beat_cnt     <= beat_cnt + 1'b1;
            out_last_q   <= ((beat_cnt + 1'b1) == BEAT_MAX);
          end
        end
        SEND: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.client_rd   = rd;
  assign bus.client_done = done;
  assign bus.server_ack  = ack;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_client  = out_client_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = (state != SETTLE);
endmodule

// File: tb/tb_bus_server_responder.sv
// Scoreboard bench for bus_server_responder: directed bursts with queued
// expected beats, pop strobes and acknowledges checked by a negedge monitor.
module tb_bus_server_responder;
  logic clk;
  logic reset;

  bus_server_responder_if #(.DATA_W(8)) bus ();

  bus_server_responder #(
    .DATA_W(8),
    .BURST_LEN(4),
    .SETTLE_CYC(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cnt, stall_cnt, valid_seen, ack_seen;
  int ack_cyc, first_hs_cyc, rel_cyc;

  logic [10:0] exp_beats [$];
  logic [3:0]  exp_rd [$];
  logic [3:0]  exp_ack [$];
  logic [7:0]  cq [4][$];
  logic [3:0]  rd_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [10:0] bt(input logic l, input logic [1:0] c, input logic [7:0] d);
    return {l, c, d};
  endfunction

  always @(posedge clk) cyc++;

  // Client models: head-of-queue word, rq while words remain, pop on client_rd.
  always @(negedge clk) rd_s = bus.client_rd;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (rd_s[i] && cq[i].size() != 0) void'(cq[i].pop_front());
    #1;
    bus.client_1_rq   = (cq[0].size() != 0);
    bus.client_1_data = (cq[0].size() != 0) ? cq[0][0] : '0;
    bus.client_2_rq   = (cq[1].size() != 0);
    bus.client_2_data = (cq[1].size() != 0) ? cq[1][0] : '0;
    bus.client_3_rq   = (cq[2].size() != 0);
    bus.client_3_data = (cq[2].size() != 0) ? cq[2][0] : '0;
    bus.client_4_rq   = (cq[3].size() != 0);
    bus.client_4_data = (cq[3].size() != 0) ? cq[3][0] : '0;
  end

  // Monitor
  logic        prev_stall = 1'b0;
  logic [11:0] prev_snap;
  always @(negedge clk) begin
    logic [10:0] eb;
    logic [3:0]  e4;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.out_valid, bus.out_last, bus.out_client, bus.out_data}, prev_snap);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_snap  = {bus.out_valid, bus.out_last, bus.out_client, bus.out_data};
      if (bus.out_valid) valid_seen++;
      if (bus.out_valid && !bus.out_ready) stall_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (hs_cnt == 0) first_hs_cyc = cyc;
        hs_cnt++;
        check("busy_in_send", bus.busy, 1);
        if (exp_beats.size() == 0)
          fail_now("beat_unexpected", {bus.out_last, bus.out_client, bus.out_data}, 0);
        else begin
          eb = exp_beats.pop_front();
          check("beat", {bus.out_last, bus.out_client, bus.out_data}, eb);
        end
      end
      if (bus.client_rd != 4'b0000) begin
        if (exp_rd.size() == 0) fail_now("rd_unexpected", bus.client_rd, 0);
        else begin
          e4 = exp_rd.pop_front();
          check("client_rd", bus.client_rd, e4);
        end
      end
      if (bus.server_ack) begin
        ack_seen++;
        ack_cyc = cyc;
        if (exp_ack.size() == 0) fail_now("ack_unexpected", bus.client_done, 0);
        else begin
          e4 = exp_ack.pop_front();
          check("client_done", bus.client_done, e4);
        end
      end else if (bus.client_done != 4'b0000) begin
        fail_now("done_without_ack", bus.client_done, 0);
      end
    end
  end

  task automatic begin_test(input logic [1:0] addr);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.address_to_be_served = addr;
    for (int i = 0; i < 4; i++) cq[i].delete();
    hs_cnt = 0; stall_cnt = 0; valid_seen = 0; ack_seen = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic add_words(input int c, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) cq[c].push_back(8'(base + i));
  endtask

  task automatic push_burst(input logic [1:0] c, input logic [7:0] base, input int n, input logic last_on_end);
    for (int i = 0; i < n; i++) begin
      exp_beats.push_back(bt(last_on_end && (i == n - 1), c, 8'(base + i)));
      exp_rd.push_back(4'b0001 << c);
    end
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int b = budget;
    while (ack_seen < n && b > 0) begin @(negedge clk); #1; b--; end
    if (ack_seen < n) fail_now({tag, "_ack_timeout"}, ack_seen, n);
  endtask

  task automatic wait_hs(input int n, input int budget, input string tag);
    int b = budget;
    while (hs_cnt < n && b > 0) begin @(negedge clk); #1; b--; end
    if (hs_cnt < n) fail_now({tag, "_hs_timeout"}, hs_cnt, n);
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.address_to_be_served = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.out_data, bus.out_valid, bus.out_client, bus.out_last,
                            bus.client_rd, bus.client_done, bus.server_ack, bus.busy}, 0);

    // 1: full burst from client 3
    begin_test(2'b10);
    add_words(2, 8'hA1, 4);
    push_burst(2'b10, 8'hA1, 4, 1'b1);
    exp_ack.push_back(4'b0100);
    release_reset();
    @(negedge clk);
    check("t1_settle_busy", bus.busy, 0);
    wait_acks(1, 40, "t1");
    check("t1_first_beat_cycle", first_hs_cyc - rel_cyc, 4);
    check("t1_ack_cycle", ack_cyc - rel_cyc, 11);
    check("t1_beats", hs_cnt, 4);

    // 2: empty grant
    begin_test(2'b01);
    exp_ack.push_back(4'b0000);
    release_reset();
    wait_acks(1, 20, "t2");
    check("t2_ack_cycle", ack_cyc - rel_cyc, 3);
    check("t2_valid_seen", valid_seen, 0);

    // 3: client 1 runs dry after two words
    begin_test(2'b00);
    add_words(0, 8'h11, 2);
    push_burst(2'b00, 8'h11, 2, 1'b0);
    exp_ack.push_back(4'b0001);
    release_reset();
    wait_acks(1, 40, "t3");
    check("t3_beats", hs_cnt, 2);

    // 4: downstream stall on beat 2
    begin_test(2'b11);
    add_words(3, 8'hC1, 4);
    push_burst(2'b11, 8'hC1, 4, 1'b1);
    exp_ack.push_back(4'b1000);
    release_reset();
    wait_hs(1, 20, "t4");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_acks(1, 40, "t4");
    check("t4_stall_cycles", stall_cnt, 5);
    check("t4_beats", hs_cnt, 4);

    // 5: address change mid-burst is ignored until the next grant
    begin_test(2'b00);
    add_words(0, 8'hB1, 4);
    add_words(3, 8'hD1, 4);
    push_burst(2'b00, 8'hB1, 4, 1'b1);
    push_burst(2'b11, 8'hD1, 4, 1'b1);
    exp_ack.push_back(4'b0001);
    exp_ack.push_back(4'b1000);
    release_reset();
    wait_hs(1, 20, "t5");
    @(posedge clk); #1;
    bus.address_to_be_served = 2'b11;
    wait_acks(2, 80, "t5");
    check("t5_beats", hs_cnt, 8);

    // 6: reset while beat 3 is on the bus; popped word 0x53 is lost
    begin_test(2'b01);
    add_words(1, 8'h51, 8);
    push_burst(2'b01, 8'h51, 2, 1'b0);
    for (int i = 0; i < 1; i++) exp_rd.push_back(4'b0010);
    push_burst(2'b01, 8'h54, 4, 1'b1);
    exp_ack.push_back(4'b0010);
    release_reset();
    wait_hs(2, 20, "t6");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    begin
      int b = 10;
      while (!bus.out_valid && b > 0) begin @(negedge clk); #1; b--; end
      if (!bus.out_valid) fail_now("t6_beat3_timeout", bus.out_valid, 1);
    end
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_drop", {bus.out_valid, bus.busy, bus.server_ack}, 0);
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    release_reset();
    wait_acks(1, 40, "t6");
    check("t6_beats", hs_cnt, 6);

    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    check("left_beats", exp_beats.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_ack", exp_ack.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
